// File: rtl/addn_loa_pipe_pkg.sv
// Shared types and helpers for the addn_loa_pipe lower-part-OR approximate adder.
// Imported by the interface, the core and the top level.
package addn_pkg;

  localparam int CNT_W  = 32;
  localparam int REC_W  = 32;
  localparam int KE_W   = 5;

  // S1 record sized for the widest legal configuration; instances use the low bits.
  typedef struct packed {
    logic              valid;
    logic [REC_W-1:0]  a;
    logic [REC_W-1:0]  b;
    logic [KE_W-1:0]   ke;
  } s1Rec_t;

  function automatic int kWidth(input int kMax);
    return (kMax < 1) ? 1 : $clog2(kMax + 1);
  endfunction

  function automatic int unsigned clampK(input int unsigned k, input int unsigned kMax);
    return (k > kMax) ? kMax : k;
  endfunction

endpackage

// File: rtl/addn_loa_pipe_if.sv
// Operand/result handshake bundle plus monitor signals for addn_loa_pipe.
// master = traffic source/sink, slave = the adder.
interface addn_loa_pipe_if
  import addn_pkg::*;
#(
  parameter int W     = 8,
  parameter int K_MAX = 4
) ();

  localparam int KW = kWidth(K_MAX);

  logic                 IN_VALID;
  logic                 IN_READY;
  logic [W-1:0]         A;
  logic [W-1:0]         B;
  logic [KW-1:0]        K;
  logic                 O_VALID;
  logic                 O_READY;
  logic [W:0]           O;
  logic                 CLR;
  logic [CNT_W-1:0]     TXN_CNT;
  logic [CNT_W-1:0]     ERR_CNT;
  logic [W:0]           ERR_MAX;

  modport master (
    output IN_VALID, A, B, K, O_READY, CLR,
    input  IN_READY, O_VALID, O, TXN_CNT, ERR_CNT, ERR_MAX
  );

  modport slave (
    input  IN_VALID, A, B, K, O_READY, CLR,
    output IN_READY, O_VALID, O, TXN_CNT, ERR_CNT, ERR_MAX
  );

endinterface

// File: rtl/addn_loa_pipe_core.sv
// Combinational lower-part-OR adder: the low KE bits are A|B, the upper part is an
// exact add seeded with the carry guessed from bit KE-1.
module addn_loa_core
  import addn_pkg::*;
#(
  parameter int W  = 8,
  parameter int KW = 3
) (
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  input  logic [KW-1:0] KE,
  output logic [W:0]    O
);

  logic [W-1:0] w_lowMask;
  logic         w_cin;
  logic [W:0]   w_hiSum;

  always_comb begin
    w_lowMask = '0;
    w_cin     = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i < int'(KE))
        w_lowMask[i] = 1'b1;
      if (i + 1 == int'(KE))
        w_cin = A[i] & B[i];
    end
  end

  // Masked low bits are zero, so adding cin at bit KE is the exact upper-part add.
  assign w_hiSum = {1'b0, A & ~w_lowMask} + {1'b0, B & ~w_lowMask}
                 + ((W+1)'(w_cin) << KE);
  assign O       = w_hiSum | {1'b0, (A | B) & w_lowMask};

endmodule

// File: rtl/addn_loa_pipe.sv
// Two-stage pipelined lower-part-OR approximate adder with valid/ready handshake.
// Define ADDN_ERRMON_EN to build the on-line error monitor (counters, max error).
module addn_loa_pipe
  import addn_pkg::*;
#(
  parameter int W     = 8,
  parameter int K_MAX = 4
) (
  input  logic           CLK,
  input  logic           RST_N,
  addn_loa_pipe_if.slave bus
);

  localparam int KW = kWidth(K_MAX);

  s1Rec_t       r_s1;
  logic         r_oValid;
  logic [W:0]   r_o;
  logic [W:0]   w_approx;
  logic         w_en;
  logic         w_unusedRec;

  // Whole pipeline advances together; bubbles are carried, not squeezed out.
  assign w_en         = ~r_oValid | bus.O_READY;
  assign bus.IN_READY = w_en;
  assign bus.O_VALID  = r_oValid;
  assign bus.O        = r_o;
  assign w_unusedRec  = ^r_s1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1 <= '0;
    end else if (w_en) begin
      r_s1.valid <= bus.IN_VALID;
      r_s1.a     <= REC_W'(bus.A);
      r_s1.b     <= REC_W'(bus.B);
      r_s1.ke    <= KE_W'(clampK(int'(bus.K), K_MAX));
    end
  end

  addn_loa_core #(.W(W), .KW(KW)) u_core (
    .A  (r_s1.a[W-1:0]),
    .B  (r_s1.b[W-1:0]),
    .KE (r_s1.ke[KW-1:0]),
    .O  (w_approx)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_oValid <= 1'b0;
      r_o      <= '0;
    end else if (w_en) begin
      r_oValid <= r_s1.valid;
      r_o      <= w_approx;
    end
  end

`ifdef ADDN_ERRMON_EN
  logic [W:0]       r_exact;
  logic [W:0]       r_errMax;
  logic [CNT_W-1:0] r_txnCnt;
  logic [CNT_W-1:0] r_errCnt;
  logic [W:0]       w_errMag;
  logic             w_xfer;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      r_exact <= '0;
    else if (w_en)
      r_exact <= {1'b0, r_s1.a[W-1:0]} + {1'b0, r_s1.b[W-1:0]};
  end

  // The OR-ed low part plus a guessed carry can land on either side of the exact sum.
  assign w_errMag = (r_exact >= r_o) ? (r_exact - r_o) : (r_o - r_exact);
  assign w_xfer   = r_oValid & bus.O_READY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_txnCnt <= '0;
      r_errCnt <= '0;
      r_errMax <= '0;
    end else if (bus.CLR) begin
      r_txnCnt <= '0;
      r_errCnt <= '0;
      r_errMax <= '0;
    end else if (w_xfer) begin
      if (r_txnCnt != '1)
        r_txnCnt <= r_txnCnt + 1'b1;
      if ((w_errMag != '0) && (r_errCnt != '1))
        r_errCnt <= r_errCnt + 1'b1;
      if (w_errMag > r_errMax)
        r_errMax <= w_errMag;
    end
  end

  assign bus.TXN_CNT = r_txnCnt;
  assign bus.ERR_CNT = r_errCnt;
  assign bus.ERR_MAX = r_errMax;
`else
  logic w_unusedClr;

  assign w_unusedClr = bus.CLR;
  assign bus.TXN_CNT = '0;
  assign bus.ERR_CNT = '0;
  assign bus.ERR_MAX = '0;
`endif

endmodule

// File: tb/tb_addn_loa_pipe.sv
// Directed self-checking bench for addn_loa_pipe (W=8, K_MAX=4); monitor expectations
// collapse to zero when ADDN_ERRMON_EN is not defined.
module tb_addn_loa_pipe;

`ifdef ADDN_ERRMON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic CLK;
  logic RST_N;
  int   checkCount;
  int   errorCount;

  addn_loa_pipe_if #(.W(8), .K_MAX(4)) bus ();

  addn_loa_pipe #(.W(8), .K_MAX(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic checkMon(input string tag, input int txn, input int err, input int emax);
    checkOutput({tag, "_txn"}, 64'(bus.TXN_CNT), MON ? 64'(txn)  : 64'd0);
    checkOutput({tag, "_err"}, 64'(bus.ERR_CNT), MON ? 64'(err)  : 64'd0);
    checkOutput({tag, "_max"}, 64'(bus.ERR_MAX), MON ? 64'(emax) : 64'd0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer one beat with O_READY high and check the result two edges after acceptance.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] k,
                               input int expO, input string tag);
    bus.IN_VALID = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.K        = k;
    checkOutput({tag, "_inReady"}, 64'(bus.IN_READY), 64'd1);
    tick();
    bus.IN_VALID = 1'b0;
    tick();
    checkOutput({tag, "_oValid"}, 64'(bus.O_VALID), 64'd1);
    checkOutput({tag, "_o"}, 64'(bus.O), 64'(expO));
  endtask

  initial begin
    checkCount   = 0;
    errorCount   = 0;
    RST_N        = 1'b0;
    bus.IN_VALID = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.K        = '0;
    bus.O_READY  = 1'b1;
    bus.CLR      = 1'b0;

    #3;
    checkOutput("rst_inReady", 64'(bus.IN_READY), 64'd1);
    checkOutput("rst_oValid", 64'(bus.O_VALID), 64'd0);
    checkOutput("rst_o", 64'(bus.O), 64'd0);
    checkMon("rst", 0, 0, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    tick();

    applyStimulus(8'd200, 8'd100, 3'd0, 300, "k0");
    applyStimulus(8'h0F, 8'h01, 3'd4, 15, "k4a");
    applyStimulus(8'h08, 8'h08, 3'd4, 24, "k4b");
    tick();
    checkMon("mon3", 3, 2, 8);

    applyStimulus(8'h08, 8'h08, 3'd7, 24, "k7clamp");
    applyStimulus(8'h55, 8'h33, 3'd2, 135, "k2");
    applyStimulus(8'hFF, 8'hFF, 3'd1, 511, "k1max");
    tick();
    checkMon("mon6", 6, 5, 8);

    // Stall: three beats offered back to back while the sink is blocked.
    bus.O_READY  = 1'b0;
    bus.IN_VALID = 1'b1;
    bus.A = 8'd1;  bus.B = 8'd2;  bus.K = 3'd0;
    tick();
    bus.A = 8'd10; bus.B = 8'd20;
    tick();
    bus.A = 8'hFF; bus.B = 8'h01;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_oValid", 64'(bus.O_VALID), 64'd1);
      checkOutput("stall_o", 64'(bus.O), 64'd3);
      checkOutput("stall_inReady", 64'(bus.IN_READY), 64'd0);
      tick();
    end
    bus.O_READY = 1'b1;
    #1;
    checkOutput("release_inReady", 64'(bus.IN_READY), 64'd1);
    tick();
    bus.IN_VALID = 1'b0;
    checkOutput("drain1_oValid", 64'(bus.O_VALID), 64'd1);
    checkOutput("drain1_o", 64'(bus.O), 64'd30);
    tick();
    checkOutput("drain2_oValid", 64'(bus.O_VALID), 64'd1);
    checkOutput("drain2_o", 64'(bus.O), 64'd256);
    tick();
    checkOutput("drain3_oValid", 64'(bus.O_VALID), 64'd0);
    checkMon("mon9", 9, 5, 8);

    // Reset with both stages holding valid beats.
    bus.O_READY  = 1'b0;
    bus.IN_VALID = 1'b1;
    bus.A = 8'd1; bus.B = 8'd1; bus.K = 3'd0;
    tick();
    bus.A = 8'd2; bus.B = 8'd2;
    tick();
    bus.IN_VALID = 1'b0;
    checkOutput("full_oValid", 64'(bus.O_VALID), 64'd1);
    checkOutput("full_o", 64'(bus.O), 64'd2);
    RST_N = 1'b0;
    #1;
    checkOutput("midrst_oValid", 64'(bus.O_VALID), 64'd0);
    checkOutput("midrst_o", 64'(bus.O), 64'd0);
    checkOutput("midrst_inReady", 64'(bus.IN_READY), 64'd1);
    checkMon("midrst", 0, 0, 0);
    repeat (2) @(negedge CLK);
    RST_N       = 1'b1;
    bus.O_READY = 1'b1;
    tick();
    checkOutput("postrst1_oValid", 64'(bus.O_VALID), 64'd0);
    tick();
    checkOutput("postrst2_oValid", 64'(bus.O_VALID), 64'd0);
    applyStimulus(8'd5, 8'd6, 3'd0, 11, "postrst");
    tick();
    checkMon("mon1", 1, 0, 0);

    // CLR coinciding with a transfer wins and the transfer is not counted.
    applyStimulus(8'd3, 8'd4, 3'd0, 7, "preclr");
    bus.CLR = 1'b1;
    tick();
    bus.CLR = 1'b0;
    checkMon("clr", 0, 0, 0);
    tick();
    checkMon("postclr", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
